// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator seven-segment display back end.
package calc_disp_pkg;

    // Calculator status encodings
    localparam logic [1:0] ST_ERRO  = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_PRINT = 2'b11;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int NUM_DIGITS = 8;

endpackage

// File: rtl/calc_display_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; values 10-15 are blank.
module seg7_decode
    import calc_disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Map one digit value onto its segment pattern
    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// Calculator display back end: captures the printed digit stream into a shadow
// buffer, commits it atomically when the print burst ends, and scans the frame
// onto an 8-digit common-anode seven-segment display.
// Optional build macro: CALC_DISP_LZB_EN enables leading-zero blanking.
module calc_display
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] scan_idx
);

    // A divide-by-one still needs a one-bit counter that simply stays at zero
    localparam int               DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [3:0]       shadow_q [NUM_DIGITS];
    logic [3:0]       shadow_d [NUM_DIGITS];
    logic [3:0]       disp_q   [NUM_DIGITS];
    logic [3:0]       disp_d   [NUM_DIGITS];
    logic             err_q, err_d;
    logic [1:0]       status_q, status_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       scan_q, scan_d;

    logic [3:0]       digit_val;
    logic [6:0]       dec_seg;
    logic             digit_blank;

    // Next-state: shadow writes, burst-end commit, error latch and scan divider
    always_comb begin
        shadow_d = shadow_q;
        disp_d   = disp_q;
        err_d    = err_q;
        status_d = status;
        div_d    = div_q;
        scan_d   = scan_q;

        if (status == ST_PRINT && pos < 4'(NUM_DIGITS)) begin
            shadow_d[pos[2:0]] = data;
        end

        // Commit only when the burst has just ended, so partial numbers never show
        if (status_q == ST_PRINT && status != ST_PRINT) begin
            disp_d = shadow_q;
            err_d  = 1'b0;
        end

        // Error wins over a simultaneous commit clear
        if (status == ST_ERRO) begin
            err_d = 1'b1;
        end

        if (div_q == DIV_LAST) begin
            div_d  = '0;
            scan_d = scan_q + 3'd1;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    // Per-digit shadow and display frame registers
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            // Hold one shadow digit and one committed digit
            always_ff @(posedge clock) begin
                if (reset) begin
                    shadow_q[gi] <= 4'd0;
                    disp_q[gi]   <= 4'd0;
                end else begin
                    shadow_q[gi] <= shadow_d[gi];
                    disp_q[gi]   <= disp_d[gi];
                end
            end
        end
    endgenerate

    // Control state: error flag, previous status, divider and scan position
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q    <= 1'b0;
            status_q <= ST_READY;
            div_q    <= '0;
            scan_q   <= 3'd0;
        end else begin
            err_q    <= err_d;
            status_q <= status_d;
            div_q    <= div_d;
            scan_q   <= scan_d;
        end
    end

    assign digit_val = disp_q[scan_q];

    seg7_decode u_decode (
        .value (digit_val),
        .seg   (dec_seg)
    );

`ifdef CALC_DISP_LZB_EN
    logic [4*NUM_DIGITS-1:0] disp_flat;
    logic [NUM_DIGITS-1:0]   lead_zero;

    // lead_zero[i] is set when digit i and every more significant digit are zero
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
            assign disp_flat[gi*4 +: 4] = disp_q[gi];
            assign lead_zero[gi]        = (disp_flat[4*NUM_DIGITS-1:gi*4] == '0);
        end
    endgenerate

    // The rightmost digit always shows, so a zero value still reads "0"
    assign digit_blank = lead_zero[scan_q] && (scan_q != 3'd0);
`else
    assign digit_blank = 1'b0;
`endif

    // Segment mux: error banner "Err" overrides the frame and blanking
    always_comb begin
        seg = dec_seg;
        if (err_q) begin
            case (scan_q)
                3'd2:        seg = SEG_E;
                3'd1, 3'd0:  seg = SEG_R;
                default:     seg = SEG_BLANK;
            endcase
        end else if (digit_blank) begin
            seg = SEG_BLANK;
        end
    end

    assign an       = ~(8'b1 << scan_q);
    assign dp       = 1'b1;
    assign scan_idx = scan_q;

endmodule

// File: tb/tb_calc_display.sv
// Directed self-checking bench for calc_display with a fast scan divider.
module tb_calc_display;

    typedef logic [7:0][6:0] frame_t;

    typedef struct {
        logic [1:0] status;
        logic [3:0] pos;
        logic [3:0] data;
    } wr_t;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SR = 7'b0101111;
`ifdef CALC_DISP_LZB_EN
    localparam logic [6:0] SZ = SB;
`else
    localparam logic [6:0] SZ = S0;
`endif

    // Expected frames, index 7 written first
    localparam frame_t F0 = {SZ, SZ, SZ, SZ, SZ, SZ, SZ, S0};
    localparam frame_t F1 = {SZ, SZ, SZ, SZ, S1, S2, S3, S4};
    localparam frame_t F2 = {SZ, SZ, SZ, SZ, S9, S9, S9, S9};
    localparam frame_t FE = {SB, SB, SB, SB, SB, SE, SR, SR};
    localparam frame_t F3 = {SZ, SZ, SZ, SZ, SZ, SZ, S5, S0};
    localparam frame_t F4 = {SZ, SZ, SZ, SZ, SZ, SZ, S5, S4};
    localparam frame_t F5 = {SZ, SZ, SZ, SZ, SZ, SZ, SZ, S4};

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] scan_idx;

    int pass_cnt  = 0;
    int total_cnt = 0;

    calc_display #(.REFRESH_DIV(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .status   (status),
        .data     (data),
        .pos      (pos),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .scan_idx (scan_idx)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %s: got %0h", name, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Visit every scan position and compare the driven segments to the frame
    task automatic sweep(input string name, input frame_t exp);
        for (int k = 0; k < 8; k++) begin
            int n = 0;
            while (scan_idx != 3'(k) && n < 40) begin
                tick();
                n++;
            end
            chk($sformatf("%s_reach%0d", name, k), {29'd0, scan_idx}, k);
            chk($sformatf("%s_seg%0d", name, k), {25'd0, seg}, {25'd0, exp[k]});
        end
    endtask

    // Apply one input cycle and confirm the committed frame is still shown
    task automatic drive_hold(input string name, input logic [1:0] st, input logic [3:0] p,
                              input logic [3:0] d, input frame_t held);
        status = st;
        pos    = p;
        data   = d;
        tick();
        chk(name, {25'd0, seg}, {25'd0, held[scan_idx]});
    endtask

    wr_t              burst1 [8];
    logic [7:0]       an_tab [8];

    initial begin
        burst1[0] = '{2'b11, 4'd0, 4'd4};
        burst1[1] = '{2'b11, 4'd1, 4'd3};
        burst1[2] = '{2'b11, 4'd2, 4'd2};
        burst1[3] = '{2'b11, 4'd3, 4'd1};
        burst1[4] = '{2'b11, 4'd4, 4'd0};
        burst1[5] = '{2'b11, 4'd5, 4'd0};
        burst1[6] = '{2'b11, 4'd6, 4'd0};
        burst1[7] = '{2'b11, 4'd7, 4'd0};
        an_tab[0] = 8'hFE; an_tab[1] = 8'hFD; an_tab[2] = 8'hFB; an_tab[3] = 8'hF7;
        an_tab[4] = 8'hEF; an_tab[5] = 8'hDF; an_tab[6] = 8'hBF; an_tab[7] = 8'h7F;

        reset  = 1'b1;
        status = 2'b10;
        pos    = 4'd0;
        data   = 4'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_an", {24'd0, an}, 32'hFE);
        chk("rst_seg", {25'd0, seg}, {25'd0, S0});
        chk("rst_scan", {29'd0, scan_idx}, 0);
        chk("rst_dp", {31'd0, dp}, 1);

        // Idle scan: advances every two cycles and wraps
        tick();
        chk("scan_hold", {29'd0, scan_idx}, 0);
        tick();
        for (int s = 1; s <= 16; s++) begin
            chk($sformatf("scan_step%0d", s), {29'd0, scan_idx}, s % 8);
            chk($sformatf("an_step%0d", s), {24'd0, an}, {24'd0, an_tab[s % 8]});
            tick();
            tick();
        end

        // Burst 4,3,2,1,0,0,0,0: frame stays old until the burst ends
        for (int i = 0; i < 8; i++) begin
            drive_hold($sformatf("b1_hold%0d", i), burst1[i].status, burst1[i].pos,
                       burst1[i].data, F0);
        end
        status = 2'b10;
        tick();
        chk("b1_commit", {25'd0, seg}, {25'd0, F1[scan_idx]});
        sweep("f1", F1);

        // Long burst writing 9s, then junk at pos 8: display frozen throughout
        for (int i = 0; i < 4; i++) begin
            drive_hold($sformatf("b2_hold%0d", i), 2'b11, 4'(i), 4'd9, F1);
        end
        for (int i = 0; i < 12; i++) begin
            drive_hold($sformatf("b2_ign%0d", i), 2'b11, 4'd8, 4'd7, F1);
        end
        status = 2'b10;
        tick();
        chk("b2_commit", {25'd0, seg}, {25'd0, F2[scan_idx]});
        sweep("f2", F2);

        // One error cycle latches the banner
        status = 2'b00;
        tick();
        chk("err_enter", {25'd0, seg}, {25'd0, FE[scan_idx]});
        status = 2'b10;
        sweep("ferr", FE);

        // Frame 50 burst: banner persists during the burst, commit clears it
        drive_hold("b3_w0", 2'b11, 4'd0, 4'd0, FE);
        drive_hold("b3_w1", 2'b11, 4'd1, 4'd5, FE);
        for (int i = 2; i < 8; i++) begin
            drive_hold($sformatf("b3_w%0d", i), 2'b11, 4'(i), 4'd0, FE);
        end
        status = 2'b10;
        tick();
        sweep("f3", F3);

        // Burst ending straight into error: commit and error in the same cycle
        drive_hold("b4_w0", 2'b11, 4'd0, 4'd4, F3);
        status = 2'b00;
        tick();
        chk("b4_err", {25'd0, seg}, {25'd0, FE[scan_idx]});
        status = 2'b10;
        sweep("ferr2", FE);
        drive_hold("b5_ign", 2'b11, 4'd8, 4'd9, FE);
        status = 2'b10;
        tick();
        sweep("f4", F4);

        // Reset in the middle of a burst discards the captured digits
        for (int i = 0; i < 4; i++) begin
            drive_hold($sformatf("b6_w%0d", i), 2'b11, 4'(i), 4'd7, F4);
        end
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        status = 2'b10;
        chk("mid_rst_scan", {29'd0, scan_idx}, 0);
        tick();
        sweep("f0", F0);

        // First burst after reset commits normally
        drive_hold("b7_w0", 2'b11, 4'd0, 4'd4, F0);
        status = 2'b10;
        tick();
        sweep("f5", F5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
